// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage buffer with a valid/ready handshake.
// It also supports hazard-driven flush and freeze, a configurable bubble value,
// and a saturating bubble counter for pipeline-efficiency debug.
// Optional feature macro: PIPE_STAGE_SKID_EN. When defined, it adds a one-entry
// skid register so that in_ready is registered and has no path from out_ready.
module pipe_stage_buf #(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt,
    input  logic              cnt_clr
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_xfer;
    logic              out_xfer;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              rdy_q, rdy_d;
`endif

    // Port-level handshake: freeze masks the held entry without discarding it
    always_comb begin
        out_valid = valid_q & ~freeze;
        out_xfer  = out_valid & out_ready;
`ifdef PIPE_STAGE_SKID_EN
        in_ready  = rdy_q & ~rst & ~flush & ~freeze;
`else
        in_ready  = ~rst & ~flush & ~freeze & (~valid_q | out_ready);
`endif
        in_xfer   = in_valid & in_ready;
    end

    assign out_data   = data_q;
    assign bubble_cnt = cnt_q;

    // Next-state for the main entry (and skid entry when present); flush beats freeze
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
`endif
        if (flush) begin
            valid_d = 1'b0;
            data_d  = BUBBLE_VAL;
`ifdef PIPE_STAGE_SKID_EN
            skid_valid_d = 1'b0;
`endif
        end else if (!freeze) begin
`ifdef PIPE_STAGE_SKID_EN
            if (out_xfer) begin
                // Drain: refill from skid first so order is preserved.
                if (skid_valid_q) begin
                    data_d       = skid_data_q;
                    valid_d      = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (in_xfer) begin
                    data_d  = in_data;
                    valid_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end else if (in_xfer) begin
                // The main entry is blocked, so the payload parks in the skid entry.
                if (valid_q) begin
                    skid_data_d  = in_data;
                    skid_valid_d = 1'b1;
                end else begin
                    data_d  = in_data;
                    valid_d = 1'b1;
                end
            end
`else
            if (in_xfer) begin
                data_d  = in_data;
                valid_d = 1'b1;
            end else if (out_xfer) begin
                valid_d = 1'b0;
            end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        rdy_d = ~skid_valid_d;
`endif
    end

    // Bubble counter: clear has priority, otherwise saturate on port-level bubbles
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (!out_valid && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= BUBBLE_VAL;
            cnt_q   <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_valid_q <= 1'b0;
            skid_data_q  <= BUBBLE_VAL;
            rdy_q        <= 1'b1;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            rdy_q        <= rdy_d;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf using a scoreboard queue plus a FIFO-level model.
// When PIPE_STAGE_SKID_EN is defined, the model capacity becomes 2.
module tb_pipe_stage_buf;

    localparam int             DW = 16;
    localparam logic [DW-1:0]  BV = 16'hB0B0;
    localparam int             CW = 4;
`ifdef PIPE_STAGE_SKID_EN
    localparam int             CAP = 2;
`else
    localparam int             CAP = 1;
`endif
    localparam int             CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, flush, freeze, in_valid, in_ready, out_valid, out_ready, cnt_clr;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] bubble_cnt;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model: a FIFO of capacity CAP plus the value shown when empty.
    logic [DW-1:0] sb_q[$];
    int            occ      = 0;
    int            exp_cnt  = 0;
    logic [DW-1:0] last_out = BV;
    bit            armed    = 1'b0;

    pipe_stage_buf #(.DATA_W(DW), .BUBBLE_VAL(BV), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .bubble_cnt(bubble_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    function automatic bit exp_ready();
        if (rst || flush || freeze) return 1'b0;
        if (CAP == 1) return (occ == 0) || out_ready;
        return occ < CAP;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each active edge, using the inputs that were present for that edge.
    initial forever begin
        bit ix, ox;
        @(posedge clk);
        ix = in_valid && exp_ready();
        ox = (occ > 0) && !freeze && out_ready && !rst && !flush;
        if (rst) begin
            sb_q.delete();
            occ      = 0;
            exp_cnt  = 0;
            last_out = BV;
            armed    = 1'b1;
        end else if (armed) begin
            if (cnt_clr) exp_cnt = 0;
            else if (!((occ > 0) && !freeze) && exp_cnt < CNT_MAX) exp_cnt++;
            if (flush) begin
                sb_q.delete();
                occ      = 0;
                last_out = BV;
            end else if (!freeze) begin
                occ = occ - int'(ox) + int'(ix);
                if (ix) sb_q.push_back(in_data);
                if (sb_q.size() > 0) last_out = sb_q[0];
            end
        end
    end

    // Monitor: whenever the DUT presents a payload, compare it with the scoreboard head.
    initial forever begin
        @(negedge clk);
        if (armed && !rst && !flush && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL out_unexpected: got %0h expected no valid output at %0t", out_data, $time);
            end else begin
                chk("out_data", 32'(out_data), 32'(sb_q[0]));
                $display("out xfer=%0d data=%0h exp=%0h", out_ready, out_data, sb_q[0]);
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    // Control and counter checks, made every cycle.
    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("in_ready", 32'(in_ready), 32'(exp_ready()));
            chk("out_valid", 32'(out_valid), 32'((occ > 0) && !freeze));
            chk("bubble_cnt", 32'(bubble_cnt), 32'(exp_cnt));
            if (occ == 0) chk("out_data_idle", 32'(out_data), 32'(last_out));
        end
    end

    task automatic step(input logic r, input logic fl, input logic fz, input logic iv,
                        input logic [DW-1:0] d, input logic ordy, input logic clr);
        rst = r; flush = fl; freeze = fz; in_valid = iv; in_data = d;
        out_ready = ordy; cnt_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        // Stream three payloads after reset.
        step(0, 0, 0, 1, 16'h1, 1, 0);
        step(0, 0, 0, 1, 16'h2, 1, 0);
        step(0, 0, 0, 1, 16'h3, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0, 1, 0);
        // Apply backpressure on a full entry.
        step(0, 0, 0, 1, 16'hAA, 1, 0);
        repeat (3) step(0, 0, 0, 1, 16'hBB, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 1, 0);
        // Flush with a simultaneous input.
        step(0, 0, 0, 1, 16'h55, 0, 0);
        step(0, 1, 0, 1, 16'h77, 1, 0);
        repeat (2) step(0, 0, 0, 0, 0, 1, 0);
        // Freeze on a held entry.
        step(0, 0, 0, 1, 16'h12, 0, 0);
        repeat (2) step(0, 0, 1, 0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 0, 1, 0);
        // Apply flush and freeze together after filling.
        step(0, 0, 0, 1, 16'h21, 0, 0);
        step(0, 0, 0, 1, 16'h22, 0, 0);
        step(0, 0, 0, 1, 16'h23, 0, 0);
        step(0, 1, 1, 1, 16'h24, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        // Counter saturation and clear.
        repeat (20) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0);
        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 70,
                 DW'($urandom), $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 3);
        end
        repeat (3) step(0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised elastic pipeline register for inter-stage buffering between fetch/decode/execute/memory/writeback. It generalises the fixed-width, always-enabled stage buffers with several additions:
- valid/ready handshake
- hazard-driven freeze and flush with a configurable bubble value
- an optional skid entry for full-throughput registered backpressure
- a saturating bubble counter for pipeline-efficiency debug
One instance sits between each pair of adjacent stages, with the bundled control and data fields packed into a single data bus.

Parameters:
DATA_W, 64, width of the packed stage payload in bits (legal 1..256)
BUBBLE_VAL, 0, value loaded into out_data on flush or reset (DATA_W bits, zero-extended)
CNT_W, 16, width of the bubble counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
flush  input  1  discard all held entries and load bubble (branch/interrupt/control hazard)
freeze  input  1  stall from hazard unit; hold contents, accept nothing
in_valid  input  1  upstream stage has a payload
in_ready  output  1  this buffer accepts the payload this cycle
in_data  input  DATA_W  upstream payload
out_valid  output  1  out_data is a real instruction, not a bubble
out_ready  input  1  downstream stage consumes out_data this cycle
out_data  output  DATA_W  held payload
bubble_cnt  output  CNT_W  saturating count of cycles with out_valid=0
cnt_clr  input  1  synchronous clear of bubble_cnt

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=BUBBLE_VAL, bubble_cnt=0, skid entry (if present) empty. in_ready=0 during the rst cycle and 1 on the first cycle after rst deasserts.
- Handshakes:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
  - in_data is sampled only on an input transfer.
- Base mode (macro absent), single main entry:
  - in_ready = !freeze & !flush & (!out_valid | out_ready); combinational from out_ready.
  - Latency: 1 cycle from input transfer to out_valid.
  - Throughput: 1 per cycle while out_ready=1.
- Main entry update priority, highest first:
  1. rst: clear to reset values.
  2. flush: out_valid<=0, out_data<=BUBBLE_VAL, skid emptied. Any simultaneous input or output transfer is discarded; in_ready is 0 that cycle.
  3. freeze: all state held. out_valid is masked to 0 at the port while freeze=1; the internal entry is retained and reappears when freeze drops. in_ready=0.
  4. Input transfer: load in_data, out_valid<=1.
  5. Output transfer without input: out_valid<=0. out_data keeps its last value; it is not reloaded with BUBBLE_VAL.
  6. Otherwise: hold.
- Simultaneous input and output transfer on a full entry: new data is loaded and out_valid stays 1 (pass-through, no bubble).
- bubble_cnt:
  - Increments each cycle in which port-level out_valid=0 and rst=0, including frozen cycles.
  - Saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr has priority over increment and takes effect on the next edge.
  - flush does not clear the counter.
- Boundaries:
  - Full entry with out_ready=0: in_ready=0 and upstream holds.
  - Empty entry: out_ready is ignored.
  - flush and freeze together: flush wins.
  - rst mid-transfer: the payload is lost with no partial state.

Optional Feature:
PIPE_STAGE_SKID_EN
- Defined:
  - Adds a one-entry skid register, and in_ready becomes a registered signal equal to !skid_full & !freeze & !flush.
  - in_ready no longer has a combinational path from out_ready.
  - If the main entry is full, out_ready=0 and an input transfer occurs, the payload goes to the skid entry.
  - When the main entry drains, it refills from skid first, preserving order, before accepting new input.
  - Capacity is 2, and throughput stays 1 per cycle under one-cycle backpressure bubbles.
  - flush empties both entries.
  - freeze holds both entries.
- Undefined:
  - Base single-entry behaviour, capacity 1.
  - in_ready is combinational as specified above.

Test Plan:
- Reset then stream: rst=1 for 2 cycles, then in_valid=1 with data 0x1,0x2,0x3 and out_ready=1 -> out_valid rises 1 cycle after the first transfer; out_data sequence 0x1,0x2,0x3 on consecutive cycles; bubble_cnt=3 (2 reset-exit cycles excluded; count from rst deassert).
- Backpressure: entry holds 0xAA, out_ready=0 for 3 cycles with in_valid=1 data 0xBB -> base: in_ready=0 for 3 cycles, out_data stays 0xAA; SKID_EN: 0xBB accepted into skid, in_ready=0 next cycle, output 0xAA then 0xBB after out_ready=1.
- Flush with simultaneous input: entry 0x55, flush=1, in_valid=1 data 0x77 -> next cycle out_valid=0, out_data=BUBBLE_VAL (0), 0x77 never appears.
- Freeze: entry 0x12, freeze=1 for 2 cycles -> out_valid=0 at port, in_ready=0, bubble_cnt +2; on freeze=0, out_valid=1 with out_data=0x12.
- Flush+freeze together with a full skid (SKID_EN) -> both entries emptied, out_valid=0 next cycle.
- Counter saturation: CNT_W=4, idle 20 cycles -> bubble_cnt=15; cnt_clr=1 -> 0 next cycle, then 1 the cycle after if still idle.
